// File: rtl/exc_pkg.sv
// Shared definitions for the exception/ERET sequencer: state encoding,
// default handler address and CP0 ExcCode values.
package exc_pkg;

    // 3-bit state encoding
    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_FLUSH    = 3'd2;
    localparam logic [2:0] ST_REDIRECT = 3'd3;
    localparam logic [2:0] ST_ERET     = 3'd4;

    typedef enum logic [2:0] {
        S_RUN      = ST_RUN,
        S_DRAIN    = ST_DRAIN,
        S_FLUSH    = ST_FLUSH,
        S_REDIRECT = ST_REDIRECT,
        S_ERET     = ST_ERET
    } state_t;

    // Exception/interrupt entry address
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/exc_sequencer_sat_counter.sv
// Saturating up-counter: increments on i_inc, holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    // Count accepted events, stopping at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET exit sequencer at the M-stage commit point.
// Drains an outstanding bridge store, flushes the pipeline for FLUSH_CYCLES,
// then presents a valid/ready redirect to the F-stage PC mux.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEFAULT,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          DRAIN_MAX    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_eret,
    input  logic        cp0_req,
    input  logic [31:0] cp0_epc,
    input  logic        bus_busy,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        stall_f,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exl_clr,
    output logic        busy,
    output logic        drain_err,
    output logic [15:0] exc_count
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flush_cnt;
    logic [7:0]  r_drain_cnt;
    logic [31:0] r_target;
    logic        w_in_run;
    logic        w_accept_exc;
    logic        w_accept_eret;
    logic        w_timeout;

    // Requests are only honoured in RUN; an exception beats a simultaneous ERET
    assign w_in_run      = (r_state == S_RUN);
    assign w_accept_exc  = w_in_run & m_valid & cp0_req;
    assign w_accept_eret = w_in_run & m_valid & m_eret & ~cp0_req;

    // Next-state decode
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_accept_exc) begin
                    w_next = bus_busy ? S_DRAIN : S_FLUSH;
                end else if (w_accept_eret) begin
                    w_next = S_ERET;
                end
            end
            S_DRAIN: begin
                if (!bus_busy) begin
                    w_next = S_FLUSH;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_next    = S_FLUSH;
                    w_timeout = 1'b1;
                end
            end
            S_ERET:     w_next = S_FLUSH;
            S_FLUSH:    if (r_flush_cnt == FLUSH_LAST) w_next = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) w_next = S_RUN;
            default:    w_next = S_RUN;
        endcase
    end

    // State, counters and captured redirect target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 4'd0;
            r_drain_cnt <= 8'd0;
            r_target    <= 32'd0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 4'd1 : 4'd0;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 8'd1 : 8'd0;
            if (w_accept_exc) begin
                r_target <= HANDLER_PC;
            end else if (w_accept_eret) begin
                r_target <= cp0_epc;
            end
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush          <= 1'b0;
            stall_f        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            exl_clr        <= 1'b0;
            busy           <= 1'b0;
            drain_err      <= 1'b0;
        end else begin
            flush          <= (w_next == S_FLUSH);
            stall_f        <= (w_next != S_RUN);
            redirect_valid <= (w_next == S_REDIRECT);
            redirect_pc    <= (w_next == S_REDIRECT) ? r_target : 32'd0;
            exl_clr        <= (w_next == S_ERET);
            busy           <= (w_next != S_RUN);
            drain_err      <= drain_err | w_timeout;
        end
    end

    // Accepted exception/interrupt count, saturating
    sat_counter #(
        .WIDTH(16)
    ) u_exc_count (
        .clk    (clk),
        .rst_n  (reset),
        .i_inc  (w_accept_exc),
        .o_count(exc_count)
    );

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomised bench for exc_sequencer against a timeline model built from the
// sequencing rules: drain length, exl_clr cycle, flush window, redirect window.
module tb_exc_sequencer;

    localparam int          FLUSH_N = 2;
    localparam int          DRAIN_N = 8;
    localparam logic [31:0] HPC     = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_eret = 1'b0;
    logic        cp0_req = 1'b0;
    logic [31:0] cp0_epc = 32'd0;
    logic        bus_busy = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        flush;
    logic        stall_f;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exl_clr;
    logic        busy;
    logic        drain_err;
    logic [15:0] exc_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_count = 16'd0;
    logic        m_err = 1'b0;

    exc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .m_valid       (m_valid),
        .m_eret        (m_eret),
        .cp0_req       (cp0_req),
        .cp0_epc       (cp0_epc),
        .bus_busy      (bus_busy),
        .redirect_ready(redirect_ready),
        .flush         (flush),
        .stall_f       (stall_f),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exl_clr       (exl_clr),
        .busy          (busy),
        .drain_err     (drain_err),
        .exc_count     (exc_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        m_valid        = 1'b0;
        m_eret         = 1'b0;
        cp0_req        = 1'b0;
        bus_busy       = 1'b0;
        redirect_ready = 1'b0;
    endtask

    // One accepted request. b = cycles bus_busy is held high starting at the
    // accept cycle; r = cycles redirect_ready is held low once redirect is offered.
    // Observed vector: {flush,stall_f,redirect_valid,exl_clr,busy,drain_err,redirect_pc,exc_count}
    task automatic run_seq(input bit exc, input bit eret, input logic [31:0] epc,
                           input int b, input int r, input string name);
        bit          eret_path = eret & ~exc;
        int          d = exc ? ((b > DRAIN_N) ? DRAIN_N : b) : 0;
        bit          tmo = exc && (b > DRAIN_N);
        int          pre = eret_path ? 1 : d;
        int          last = pre + FLUSH_N + 1 + r;
        logic [31:0] tgt = exc ? HPC : epc;
        logic [15:0] cnt_after = (exc && m_count != 16'hFFFF) ? m_count + 16'd1 : m_count;
        logic        e_flush, e_stall, e_valid, e_exl, e_busy, e_err;
        logic [31:0] e_pc;
        logic [53:0] exp_v, got_v;
        int          t;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (i == 0) begin
                m_valid = 1'b1;
                cp0_req = exc;
                m_eret  = eret;
                cp0_epc = epc;
            end else begin
                m_valid = 1'($urandom);
                cp0_req = 1'($urandom);
                m_eret  = 1'($urandom);
                cp0_epc = $urandom;
            end
            if (exc && i <= d) bus_busy = (i < b);
            else               bus_busy = 1'($urandom);
            if (i == last)                redirect_ready = 1'b1;
            else if (i >= last - r)       redirect_ready = 1'b0;
            else                          redirect_ready = 1'($urandom);
            @(posedge clk);
            #1;
            t = i + 1;
            e_flush = 1'b0; e_stall = 1'b1; e_valid = 1'b0; e_exl = 1'b0; e_busy = 1'b1;
            e_pc = 32'd0;
            if (t <= pre) begin
                e_exl = eret_path;
            end else if (t <= pre + FLUSH_N) begin
                e_flush = 1'b1;
            end else if (t <= last) begin
                e_valid = 1'b1;
                e_pc    = tgt;
            end else begin
                e_stall = 1'b0;
                e_busy  = 1'b0;
            end
            e_err = m_err | (tmo && t >= d + 1);
            exp_v = {e_flush, e_stall, e_valid, e_exl, e_busy, e_err, e_pc, cnt_after};
            got_v = {flush, stall_f, redirect_valid, exl_clr, busy, drain_err, redirect_pc, exc_count};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s t=%0d got=%h expected=%h", name, t, got_v, exp_v);
            end
        end
        clear_inputs();
        m_count = cnt_after;
        m_err   = m_err | tmo;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({flush, stall_f, redirect_valid, exl_clr, busy, drain_err, redirect_pc, exc_count} !== 54'd0) begin
            bad++;
            $display("FAIL reset_state got=%h expected=0",
                     {flush, stall_f, redirect_valid, exl_clr, busy, drain_err, redirect_pc, exc_count});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_exception();
        run_seq(1'b1, 1'b0, $urandom, 0, 0, "exc_entry");
        run_seq(1'b1, 1'b0, $urandom, 0, 0, "exc_back_to_back");
    endtask

    task automatic test_drain();
        run_seq(1'b1, 1'b0, $urandom, 3, 0, "drain_3");
        run_seq(1'b1, 1'b0, $urandom, 1, 0, "drain_1");
        run_seq(1'b1, 1'b0, $urandom, DRAIN_N, 0, "drain_edge");
    endtask

    task automatic test_drain_timeout();
        run_seq(1'b1, 1'b0, $urandom, DRAIN_N + 5, 0, "drain_timeout");
        run_seq(1'b1, 1'b0, $urandom, 0, 1, "drain_err_sticky");
    endtask

    task automatic test_eret();
        run_seq(1'b0, 1'b1, 32'h0000_3010, 0, 0, "eret_3010");
        run_seq(1'b0, 1'b1, $urandom, 0, 2, "eret_random");
    endtask

    task automatic test_conflict();
        run_seq(1'b1, 1'b1, 32'h0000_3010, 0, 0, "conflict");
    endtask

    task automatic test_ignore_invalid();
        logic [19:0] got_v;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_valid  = 1'b0;
            cp0_req  = 1'b1;
            m_eret   = 1'b1;
            bus_busy = 1'($urandom);
            @(posedge clk);
            #1;
            got_v = {busy, stall_f, flush, exl_clr, exc_count};
            total++;
            if (got_v !== {4'b0000, m_count}) begin
                bad++;
                $display("FAIL ignore_invalid cycle=%0d got=%h expected=%h", i, got_v, {4'b0000, m_count});
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        run_seq(1'b1, 1'b0, $urandom, 2, 4, "backpressure");
    endtask

    task automatic test_random();
        bit exc, eret;
        for (int n = 0; n < 20; n++) begin
            exc  = 1'($urandom);
            eret = exc ? 1'($urandom) : 1'b1;
            run_seq(exc, eret, $urandom, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m_valid  = 1'b1;
        cp0_req  = 1'b1;
        bus_busy = 1'b0;
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (flush !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre flush=%b expected=1", flush);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({flush, stall_f, redirect_valid, exl_clr, busy, drain_err, redirect_pc, exc_count} !== 54'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h expected=0",
                     {flush, stall_f, redirect_valid, exl_clr, busy, drain_err, redirect_pc, exc_count});
        end
        @(negedge clk);
        reset   = 1'b1;
        m_count = 16'd0;
        m_err   = 1'b0;
        run_seq(1'b1, 1'b0, $urandom, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_exception();
        test_drain();
        test_drain_timeout();
        test_eret();
        test_conflict();
        test_ignore_invalid();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
